// File: rtl/shiftr_engine.sv
// -----------------------------------------------------------------------------
// shiftr_engine
//
// Multi-mode serial shift engine. A WIDTH-bit word is parallel-loaded, then a
// start command runs a latched number of single-bit shifts, one per cycle
// with enable high. Each step reports the bit that fell out on so. Operations
// are logical right/left with a fill bit, rotate right and arithmetic right.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   data    parallel load value
//   load    load data into o; aborts any running operation
//   start   begin an operation (accepted only while idle)
//   mode    00 logical right, 01 logical left, 10 rotate right, 11 arith right
//   amt     number of single-bit steps (0 gives an immediate done)
//   w       fill bit for the logical modes
//   enable  advance one step per cycle while shifting; low stalls
//   o       register contents
//   so      bit most recently shifted out
//   busy    high while an operation is in progress
//   done    one-cycle completion pulse
// -----------------------------------------------------------------------------
module shiftr_engine #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             w,
  input  logic             enable,
  output logic [WIDTH-1:0] o,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_LSL = 2'b01;
  localparam logic [1:0] M_ROR = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             so_q, so_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             w_q, w_d;

  // One-bit step of the latched operation applied to the current word.
  logic [WIDTH-1:0] step_o;
  logic             step_so;

  always_comb begin
    step_o  = o_q;
    step_so = so_q;
    case (mode_q)
      M_LSR: begin
        step_o  = {w_q, o_q[WIDTH-1:1]};
        step_so = o_q[0];
      end
      M_LSL: begin
        step_o  = {o_q[WIDTH-2:0], w_q};
        step_so = o_q[WIDTH-1];
      end
      M_ROR: begin
        step_o  = {o_q[0], o_q[WIDTH-1:1]};
        step_so = o_q[0];
      end
      default: begin
        step_o  = {o_q[WIDTH-1], o_q[WIDTH-1:1]};
        step_so = o_q[0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    so_d    = so_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    w_d     = w_q;

    if (load) begin
      // Load wins over start and over any step; so keeps its last value.
      o_d     = data;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (amt != '0) begin
              mode_d  = mode;
              w_d     = w;
              cnt_d   = amt;
              state_d = S_SHIFT;
            end else begin
              // Zero-length operation completes immediately.
              done_d = 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (enable) begin
            o_d   = step_o;
            so_d  = step_so;
            cnt_d = cnt_q - 1'b1;
            // Final step: leave SHIFT on the same edge so a start seen
            // during the done cycle is accepted without a gap.
            if (cnt_q == AMT_W'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      so_q    <= so_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      w_q     <= w_d;
    end
  end

  assign o    = o_q;
  assign so   = so_q;
  assign busy = (state_q == S_SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_shiftr_engine.sv
// -----------------------------------------------------------------------------
// tb_shiftr_engine
//
// Self-checking bench for shiftr_engine at WIDTH=8, AMT_W=4. Directed
// scenarios plus randomized operations compared against a closed-form model
// of each shift mode (whole-amount arithmetic, not step by step).
// -----------------------------------------------------------------------------
module tb_shiftr_engine;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data;
  logic          load;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] amt;
  logic          w;
  logic          enable;
  logic [W-1:0]  o;
  logic          so;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  shiftr_engine #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .load   (load),
    .start  (start),
    .mode   (mode),
    .amt    (amt),
    .w      (w),
    .enable (enable),
    .o      (o),
    .so     (so),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Closed-form result of n (>=1) shifts of d: returns {so, o}.
  function automatic logic [W:0] ref_op(input logic [W-1:0] d, input logic [1:0] m,
                                        input int n, input logic wf);
    logic [W-1:0] ones;
    logic [W-1:0] r;
    logic         s;
    int           k;
    ones = '1;
    r = '0;
    s = 1'b0;
    case (m)
      2'd0: begin
        r = (n >= W) ? {W{wf}} : ((d >> n) | (wf ? ~(ones >> n) : '0));
        s = (n <= W) ? d[n-1] : wf;
      end
      2'd1: begin
        r = (n >= W) ? {W{wf}} : ((d << n) | (wf ? ~(ones << n) : '0));
        s = (n <= W) ? d[W-n] : wf;
      end
      2'd2: begin
        k = n % W;
        r = (k == 0) ? d : ((d >> k) | (d << (W - k)));
        s = d[(n-1) % W];
      end
      default: begin
        r = (n >= W) ? {W{d[W-1]}} : W'($signed(d) >>> n);
        s = (n <= W) ? d[n-1] : d[W-1];
      end
    endcase
    return {s, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] d);
    data = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] m, input logic [AW-1:0] a, input logic wf);
    mode  = m;
    amt   = a;
    w     = wf;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Steps until done (bounded); counts enabled edges, flags early busy drop.
  task automatic wait_done(input int stall_pct, output int en_cnt,
                           output bit timed_out, output bit busy_gap);
    en_cnt    = 0;
    timed_out = 1'b1;
    busy_gap  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      enable = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      tick();
      if (enable) en_cnt++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (!busy) busy_gap = 1'b1;
    end
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (o !== 8'h00)  begin errors++; $display("FAIL reset_o: got %h expected 00", o); end
    checks++; if (so !== 1'b0)  begin errors++; $display("FAIL reset_so: got %b expected 0", so); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    $display("txn reset o=%h so=%b busy=%b done=%b", o, so, busy, done);
  endtask

  task automatic test_logical_right();
    int en_cnt; bit to; bit gap;
    do_load(8'hB4);
    checks++; if (o !== 8'hB4) begin errors++; $display("FAIL lsr_load: got %h expected b4", o); end
    start_op(2'b00, 4'd3, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lsr_busy: got %b expected 1", busy); end
    wait_done(0, en_cnt, to, gap);
    checks++; if (to || en_cnt != 3) begin errors++; $display("FAIL lsr_latency: got %0d (timeout=%b) expected 3", en_cnt, to); end
    checks++; if (gap) begin errors++; $display("FAIL lsr_busy_gap: got gap expected none"); end
    checks++; if (o !== 8'hF6) begin errors++; $display("FAIL lsr_o: got %h expected f6", o); end
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL lsr_so: got %b expected 1", so); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lsr_done_busy: got %b expected 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lsr_done_pulse: got %b expected 0", done); end
    $display("txn lsr B4 amt=3 -> o=%h so=%b", o, so);
  endtask

  task automatic test_arith_left();
    int en_cnt; bit to; bit gap;
    do_load(8'h90);
    start_op(2'b11, 4'd2, 1'b1);
    wait_done(0, en_cnt, to, gap);
    checks++; if (to || en_cnt != 2) begin errors++; $display("FAIL asr_latency: got %0d expected 2", en_cnt); end
    checks++; if (o !== 8'hE4) begin errors++; $display("FAIL asr_o: got %h expected e4", o); end
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL asr_so: got %b expected 0", so); end
    $display("txn asr 90 amt=2 -> o=%h so=%b", o, so);
    do_load(8'h81);
    start_op(2'b01, 4'd1, 1'b0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL lsl_start: got busy=%b done=%b expected 1 0", busy, done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL lsl_done: got %b expected 1", done); end
    checks++; if (o !== 8'h02) begin errors++; $display("FAIL lsl_o: got %h expected 02", o); end
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL lsl_so: got %b expected 1", so); end
    $display("txn lsl 81 amt=1 -> o=%h so=%b", o, so);
  endtask

  task automatic test_rotate_wide();
    int en_cnt; bit to; bit gap;
    do_load(8'hA5);
    start_op(2'b10, 4'd9, 1'b0);
    wait_done(0, en_cnt, to, gap);
    checks++; if (to || en_cnt != 9) begin errors++; $display("FAIL ror_latency: got %0d expected 9", en_cnt); end
    checks++; if (o !== 8'hD2) begin errors++; $display("FAIL ror_o: got %h expected d2", o); end
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL ror_so: got %b expected 1", so); end
    $display("txn ror A5 amt=9 -> o=%h so=%b", o, so);
    do_load(8'hFF);
    start_op(2'b00, 4'd15, 1'b0);
    wait_done(0, en_cnt, to, gap);
    checks++; if (to || en_cnt != 15) begin errors++; $display("FAIL lsr15_latency: got %0d expected 15", en_cnt); end
    checks++; if (o !== 8'h00) begin errors++; $display("FAIL lsr15_o: got %h expected 00", o); end
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL lsr15_so: got %b expected 0", so); end
    $display("txn lsr FF amt=15 -> o=%h so=%b", o, so);
  endtask

  task automatic test_stall();
    int en_cnt; bit to; bit gap;
    do_load(8'hC3);
    start_op(2'b00, 4'd4, 1'b1);
    // Scramble the command inputs; the running operation must not see them.
    mode = 2'b11;
    w    = 1'b0;
    enable = 1'b1;
    tick();
    checks++; if (o !== 8'hE1 || so !== 1'b1) begin errors++; $display("FAIL stall_step1: got %h/%b expected e1/1", o, so); end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = (i == 0);
      amt   = 4'd2;
      tick();
      checks++;
      if (o !== 8'hE1 || so !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got o=%h so=%b busy=%b done=%b expected e1 1 1 0", o, so, busy, done);
      end
    end
    start = 1'b0;
    wait_done(0, en_cnt, to, gap);
    checks++; if (to || en_cnt != 3) begin errors++; $display("FAIL stall_latency: got %0d expected 3", en_cnt); end
    checks++; if (o !== 8'hFC || so !== 1'b0) begin errors++; $display("FAIL stall_result: got %h/%b expected fc/0", o, so); end
    $display("txn stall lsr C3 amt=4 -> o=%h so=%b", o, so);
    // Zero-length operation.
    start_op(2'b01, 4'd0, 1'b1);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL amt0_done: got done=%b busy=%b expected 1 0", done, busy); end
    checks++; if (o !== 8'hFC || so !== 1'b0) begin errors++; $display("FAIL amt0_o: got %h/%b expected fc/0", o, so); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL amt0_after: got done=%b busy=%b expected 0 0", done, busy); end
    $display("txn amt0 -> o=%h", o);
  endtask

  task automatic test_abort_reset();
    bit saw_done;
    do_load(8'h55);
    start_op(2'b00, 4'd8, 1'b0);
    tick();
    tick();
    do_load(8'h3C);
    checks++; if (o !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort: got o=%h busy=%b done=%b expected 3c 0 0", o, busy, done); end
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL abort_so: got %b expected 0", so); end
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done || o !== 8'h3C) begin errors++; $display("FAIL abort_quiet: got o=%h activity=%b expected 3c 0", o, saw_done); end
    $display("txn abort -> o=%h", o);
    do_load(8'h3D);
    start_op(2'b10, 4'd8, 1'b0);
    tick();
    checks++; if (so !== 1'b1) begin errors++; $display("FAIL rstmid_pre_so: got %b expected 1", so); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o !== 8'h00 || so !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid: got o=%h so=%b busy=%b done=%b expected 00 0 0 0", o, so, busy, done); end
    $display("txn reset-mid-op -> o=%h", o);
  endtask

  task automatic test_back_to_back();
    int en_cnt; bit to; bit gap;
    data  = 8'h77;
    load  = 1'b1;
    start = 1'b1;
    mode  = 2'b00;
    amt   = 4'd3;
    tick();
    load  = 1'b0;
    start = 1'b0;
    checks++; if (o !== 8'h77 || busy !== 1'b0) begin errors++; $display("FAIL load_start: got o=%h busy=%b expected 77 0", o, busy); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || o !== 8'h77) begin errors++; $display("FAIL load_start_after: got o=%h busy=%b done=%b expected 77 0 0", o, busy, done); end
    start_op(2'b01, 4'd2, 1'b1);
    wait_done(0, en_cnt, to, gap);
    checks++; if (to || o !== 8'hDF || so !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b expected df/1", o, so); end
    start_op(2'b11, 4'd3, 1'b0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done); end
    wait_done(0, en_cnt, to, gap);
    checks++; if (to || en_cnt != 3) begin errors++; $display("FAIL b2b_latency: got %0d expected 3", en_cnt); end
    checks++; if (o !== 8'hFB || so !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b expected fb/1", o, so); end
    $display("txn back-to-back -> o=%h so=%b", o, so);
  endtask

  task automatic test_random();
    int en_cnt; bit to; bit gap;
    logic [W-1:0]  d;
    logic [1:0]    m;
    logic [AW-1:0] a;
    logic          wf;
    logic [W:0]    exp_v;
    logic          model_so;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_so = 1'b0;
    for (int k = 0; k < 40; k++) begin
      d  = W'($urandom);
      m  = 2'($urandom_range(3));
      a  = AW'($urandom_range(15));
      wf = 1'($urandom_range(1));
      do_load(d);
      start_op(m, a, wf);
      mode = 2'($urandom);
      amt  = AW'($urandom);
      w    = 1'($urandom);
      if (a == 0) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || o !== d || so !== model_so) begin
          errors++;
          $display("FAIL rand_amt0: got o=%h so=%b done=%b busy=%b expected %h %b 1 0", o, so, done, busy, d, model_so);
        end
      end else begin
        exp_v = ref_op(d, m, int'(a), wf);
        wait_done(30, en_cnt, to, gap);
        checks++;
        if (to || gap || en_cnt != int'(a) || busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_timing: got steps=%0d timeout=%b gap=%b busy=%b expected steps=%0d", en_cnt, to, gap, busy, a);
        end
        checks++;
        if (o !== exp_v[W-1:0] || so !== exp_v[W]) begin
          errors++;
          $display("FAIL rand_result: d=%h mode=%0d amt=%0d w=%b got %h/%b expected %h/%b", d, m, a, wf, o, so, exp_v[W-1:0], exp_v[W]);
        end
        model_so = exp_v[W];
      end
      $display("txn rand d=%h mode=%0d amt=%0d w=%b -> o=%h so=%b", d, m, a, wf, o, so);
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand_pulse: got %b expected 0", done); end
    end
  endtask

  initial begin
    rst    = 1'b1;
    data   = '0;
    load   = 1'b0;
    start  = 1'b0;
    mode   = 2'b00;
    amt    = '0;
    w      = 1'b0;
    enable = 1'b1;
    test_reset();
    test_logical_right();
    test_arith_left();
    test_rotate_wide();
    test_stall();
    test_abort_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
